shiftreg_seq: RTL and testbench

SHIFTREG_SEQ -- requirements
Module: shiftreg_seq

---
 rtl/shiftreg_seq.sv | 133 +++++++++++++
 tb/tb_shiftreg_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/shiftreg_seq.sv
// Load-and-shift sequencer for an external negedge-updated shift register.
// Loads a word, applies up to N single-bit shifts with feedback, and reports the final contents.
//
//   state | meaning
//   IDLE  | waiting for start, all register controls parked at 0
//   LOAD  | parallel-load the captured word into the register
//   SHIFT | one shift per cycle, register output fed back to its input
//   DONE  | single-cycle completion pulse, result already captured
module shiftreg_seq #(
    parameter int N  = 16,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [N-1:0]  din,
    input  logic          dir,
    input  logic [CW-1:0] count,
    input  logic          fill,
    input  logic [N-1:0]  sr_dout,
    output logic          sr_ld,
    output logic          sr_mode,
    output logic          sr_sin,
    output logic [N-1:0]  sr_din,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] N_CW   = CW'(N);
    localparam logic [CW-1:0] CNT_TC = CW'(1);

    state_t        state;
    logic [CW-1:0] rem;
    logic          dir_q;
    logic          fill_q;
    logic [CW-1:0] count_sat;

    assign count_sat = (count > N_CW) ? N_CW : count;

    // Outputs are registered against the state being entered; the register
    // itself moves on the following negedge, so sr_dout is stable here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rem     <= '0;
            dir_q   <= 1'b0;
            fill_q  <= 1'b0;
            sr_ld   <= 1'b0;
            sr_mode <= 1'b0;
            sr_sin  <= 1'b0;
            sr_din  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            sr_ld   <= 1'b0;
            sr_mode <= 1'b0;
            sr_sin  <= 1'b0;
            sr_din  <= '0;
            done    <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= LOAD;
                        busy   <= 1'b1;
                        rem    <= count_sat;
                        dir_q  <= dir;
                        fill_q <= fill;
                        sr_ld  <= 1'b1;
                        sr_din <= din;
                    end
                end

                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        rem   <= '0;
                    end else if (rem != '0) begin
                        state   <= SHIFT;
                        sr_mode <= dir_q;
                        sr_sin  <= fill_q;
                        sr_din  <= sr_dout;
                    end else begin
                        state  <= DONE;
                        done   <= 1'b1;
                        result <= sr_dout;
                    end
                end

                SHIFT: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        rem   <= '0;
                    end else if (rem == CNT_TC) begin
                        state  <= DONE;
                        rem    <= '0;
                        done   <= 1'b1;
                        result <= sr_dout;
                    end else begin
                        rem     <= rem - CNT_TC;
                        sr_mode <= dir_q;
                        sr_sin  <= fill_q;
                        sr_din  <= sr_dout;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    rem   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shiftreg_seq.sv
// Bench for shiftreg_seq: models the external negedge shift register and checks
// latency, outputs and final results against an arithmetic shift model.
module tb_shiftreg_seq;

    localparam int N  = 16;
    localparam int CW = 5;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [N-1:0]  din;
    logic          dir;
    logic [CW-1:0] count;
    logic          fill;
    logic [N-1:0]  sr_dout;
    logic          sr_ld;
    logic          sr_mode;
    logic          sr_sin;
    logic [N-1:0]  sr_din;
    logic          busy;
    logic          done;
    logic [N-1:0]  result;

    int n_checks = 0;
    int n_fail   = 0;
    logic [N-1:0] last_exp = '0;

    shiftreg_seq #(.N(N), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .din(din), .dir(dir), .count(count), .fill(fill),
        .sr_dout(sr_dout), .sr_ld(sr_ld), .sr_mode(sr_mode), .sr_sin(sr_sin),
        .sr_din(sr_din), .busy(busy), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controlled register: loads or shifts its parallel input on the negedge.
    always @(negedge clk) begin
        if (sr_ld)
            sr_dout <= sr_din;
        else if (sr_mode)
            sr_dout <= {sr_din[N-2:0], sr_sin};
        else
            sr_dout <= {sr_sin, sr_din[N-1:1]};
    end

    function automatic logic [N-1:0] ref_shift(input logic [N-1:0] v, input int n,
                                               input logic d, input logic f);
        int w;
        w = int'(v);
        for (int i = 0; i < n; i++) begin
            if (d) w = (w * 2 + int'(f)) % 65536;
            else   w = w / 2 + int'(f) * 32768;
        end
        return N'(w);
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_outputs(input string tag);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_ld"}, sr_ld, 1'b0);
        chk1({tag, "_mode"}, sr_mode, 1'b0);
        chk1({tag, "_sin"}, sr_sin, 1'b0);
        chkw({tag, "_din"}, sr_din, '0);
    endtask

    // Called #1 after a posedge with the DUT idle; start is sampled at the next edge.
    task automatic run_job(input logic [N-1:0] d, input logic dr, input logic [CW-1:0] c,
                           input logic f, input bit poke_start, input bit abort_done,
                           input bit abort_idle);
        int cs, cyc, busy_cnt, done_cnt, done_cyc;
        logic [N-1:0] exp;
        cs  = (c > 5'd16) ? 16 : int'(c);
        exp = ref_shift(d, cs, dr, f);
        din = d; dir = dr; count = c; fill = f; start = 1'b1; abort = abort_idle;
        next_cycle();
        start = 1'b0; abort = 1'b0;
        din = N'($urandom); dir = 1'($urandom); count = CW'($urandom); fill = 1'($urandom);
        cyc = 1; busy_cnt = 0; done_cnt = 0; done_cyc = 0;
        chk1("accept_busy", busy, 1'b1);
        chk1("load_ld", sr_ld, 1'b1);
        chkw("load_din", sr_din, d);
        while (busy && cyc < 64) begin
            busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk1("done_ld", sr_ld, 1'b0);
                chkw("done_din", sr_din, '0);
                if (abort_done) abort = 1'b1;
            end else if (cyc >= 2) begin
                chk1("shift_ld", sr_ld, 1'b0);
                chk1("shift_mode", sr_mode, dr);
                chk1("shift_sin", sr_sin, f);
                chkw("shift_din", sr_din, ref_shift(d, cyc - 2, dr, f));
            end
            start = (poke_start && cyc == 2);
            next_cycle();
            abort = 1'b0;
            cyc++;
        end
        start = 1'b0;
        chki("busy_cycles", busy_cnt, cs + 2);
        chki("done_cycle", done_cyc, cs + 2);
        chki("done_pulses", done_cnt, 1);
        chkw("result", result, exp);
        last_exp = exp;
        if (poke_start) begin
            next_cycle();
            chk1("not_queued", busy, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        din = '0; dir = 1'b0; count = '0; fill = 1'b0;
        next_cycle();
        idle_outputs("reset");
        chkw("reset_result", result, '0);

        next_cycle();
        rst_n = 1'b1;
        // Start offered on the very first edge after release.
        run_job(16'h00C0, 1'b0, 5'd1, 1'b1, 0, 0, 0);
        chkw("right_const", result, 16'h8060);
        run_job(16'h00C0, 1'b1, 5'd1, 1'b1, 0, 0, 0);
        chkw("left_const", result, 16'h0181);
        run_job(16'h00C0, 1'b1, 5'd4, 1'b0, 0, 0, 0);
        chkw("left4_const", result, 16'h0C00);
        run_job(16'h0F0F, 1'b0, 5'd0, 1'b1, 0, 0, 0);
        chkw("zero_const", result, 16'h0F0F);
        run_job(16'hFFFF, 1'b0, 5'd20, 1'b0, 0, 0, 0);
        chkw("sat_const", result, 16'h0000);
        run_job(16'h1234, 1'b1, 5'd16, 1'b1, 0, 0, 0);
        run_job(16'hA5A5, 1'b0, 5'd3, 1'b1, 1, 0, 0);
        run_job(16'h5A5A, 1'b1, 5'd0, 1'b0, 1, 0, 0);
        run_job(16'h8001, 1'b0, 5'd2, 1'b1, 0, 1, 0);
        run_job(16'h3C3C, 1'b1, 5'd5, 1'b0, 0, 0, 1);
        idle_outputs("idle");

        // Abort on the second SHIFT cycle of a count=8 job.
        din = 16'hBEEF; dir = 1'b1; count = 5'd8; fill = 1'b1; start = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        next_cycle();
        chk1("pre_abort_busy", busy, 1'b1);
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        idle_outputs("abort_shift");
        chkw("abort_result", result, last_exp);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            chk1("abort_no_done", done, 1'b0);
        end

        // Abort coinciding with the final shift wins over count expiry.
        din = 16'h0F0F; dir = 1'b0; count = 5'd1; fill = 1'b1; start = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        idle_outputs("abort_last");
        chkw("abort_last_result", result, last_exp);

        // Abort during LOAD.
        din = 16'h7777; count = 5'd5; start = 1'b1;
        next_cycle();
        start = 1'b0;
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        idle_outputs("abort_load");
        chkw("abort_load_result", result, last_exp);

        for (int i = 0; i < 12; i++)
            run_job(N'($urandom), 1'($urandom_range(0, 1)), CW'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), 0, 0, 0);

        // Reset in the middle of SHIFT.
        din = 16'hC3C3; dir = 1'b1; count = 5'd8; fill = 1'b1; start = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        next_cycle();
        chk1("pre_reset_mode", sr_mode, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        idle_outputs("async_reset");
        chkw("async_reset_result", result, '0);
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            chk1("post_reset_busy", busy, 1'b0);
            chk1("post_reset_done", done, 1'b0);
        end
        run_job(16'h00C0, 1'b0, 5'd1, 1'b1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
